// File: rtl/fetch_unit_pkg.sv
// Shared 6502 definitions: fetch FSM encoding, reset vector addresses and
// the opcode/register/ALU names reused by the fetch and decode logic.
package fetch_unit_pkg;

    typedef enum logic [3:0] {
        S_RST,
        S_VEC0,
        S_VEC1,
        S_VEC2,
        S_OP,
        S_B1,
        S_B2,
        S_B3,
        S_OUT
    } fetch_state_t;

    localparam logic [15:0] VEC_RESET_LO = 16'hFFFC;
    localparam logic [15:0] VEC_RESET_HI = 16'hFFFD;

    localparam logic [7:0] OP_BRK = 8'h00;
    localparam logic [7:0] OP_JSR = 8'h20;
    localparam logic [7:0] OP_RTI = 8'h40;
    localparam logic [7:0] OP_RTS = 8'h60;

    typedef enum logic [1:0] {
        REG_A,
        REG_X,
        REG_Y,
        REG_S
    } reg_sel_t;

    typedef enum logic [2:0] {
        ALU_ADC,
        ALU_SBC,
        ALU_AND,
        ALU_ORA,
        ALU_EOR,
        ALU_ASL,
        ALU_LSR,
        ALU_ROR
    } alu_op_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Memory read port, redirect request and instruction hand-off of the fetch unit.
interface fetch_unit_if;
    // ir_valid/ir_ready: an instruction transfers on a rising edge where both
    // are high; once ir_valid rises, ir_* stay stable until that transfer
    // (or a redirect) and ir_valid never depends on ir_ready.
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic [7:0]  ir_opcode;
    logic [15:0] ir_operand;
    logic [15:0] ir_pc;
    logic [1:0]  ir_len;

    modport master (
        output mem_addr, mem_rd, ir_valid, ir_opcode, ir_operand, ir_pc, ir_len,
        input  mem_data, redirect, redirect_pc, ir_ready
    );

    modport slave (
        input  mem_addr, mem_rd, ir_valid, ir_opcode, ir_operand, ir_pc, ir_len,
        output mem_data, redirect, redirect_pc, ir_ready
    );
endinterface

// File: rtl/fetch_unit_inst_len.sv
// Instruction length (1..3 bytes) from the opcode byte alone; shared with the decoder.
module inst_len
    import fetch_unit_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [1:0] len
);

    // First match wins: implied/stack forms, then absolute-style, else two bytes.
    always_comb begin
        len = 2'd2;
        if (opcode == OP_BRK || opcode == OP_RTI || opcode == OP_RTS ||
            (opcode[3:2] == 2'b10 && !opcode[0])) begin
            len = 2'd1;
        end else if (opcode == OP_JSR || opcode[4:2] == 3'b011 ||
                     (opcode[4:2] == 3'b110 && opcode[0]) ||
                     opcode[4:2] == 3'b111) begin
            len = 2'd3;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Byte-serial instruction fetch: loads the reset vector, assembles 1-3 byte
// instructions from a one-cycle-latency memory and hands them downstream.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus,
    output fetch_state_t dbg_state
);

    fetch_state_t state;
    logic [15:0]  pc;
    logic [1:0]   op_len;

    inst_len u_inst_len (
        .opcode (bus.mem_data),
        .len    (op_len)
    );

    assign dbg_state    = state;
    assign bus.ir_valid = (state == S_OUT);

    // Read strobe and address depend only on state and registered pc/length.
    always_comb begin
        bus.mem_rd   = 1'b0;
        bus.mem_addr = 16'h0000;
        case (state)
            S_VEC0: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = VEC_RESET_LO;
            end
            S_VEC1: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = VEC_RESET_HI;
            end
            S_OP: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = pc;
            end
            S_B1: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = pc + 16'd1;
            end
            S_B2: begin
                if (bus.ir_len == 2'd3) begin
                    bus.mem_rd   = 1'b1;
                    bus.mem_addr = pc + 16'd2;
                end
            end
            default: begin
                bus.mem_rd   = 1'b0;
                bus.mem_addr = 16'h0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_RST;
            pc             <= 16'h0000;
            bus.ir_opcode  <= 8'h00;
            bus.ir_operand <= 16'h0000;
            bus.ir_pc      <= 16'h0000;
            bus.ir_len     <= 2'd1;
        end else if (bus.redirect && state != S_RST) begin
            // Returning to S_OP drops whatever read data is still in flight.
            state <= S_OP;
            pc    <= bus.redirect_pc;
        end else begin
            case (state)
                S_RST:  state <= S_VEC0;
                S_VEC0: state <= S_VEC1;
                S_VEC1: begin
                    pc[7:0] <= bus.mem_data;
                    state   <= S_VEC2;
                end
                S_VEC2: begin
                    pc[15:8] <= bus.mem_data;
                    state    <= S_OP;
                end
                S_OP:   state <= S_B1;
                S_B1: begin
                    bus.ir_opcode  <= bus.mem_data;
                    bus.ir_len     <= op_len;
                    bus.ir_pc      <= pc;
                    bus.ir_operand <= 16'h0000;
                    state          <= (op_len == 2'd1) ? S_OUT : S_B2;
                end
                S_B2: begin
                    bus.ir_operand[7:0] <= bus.mem_data;
                    state               <= (bus.ir_len == 2'd3) ? S_B3 : S_OUT;
                end
                S_B3: begin
                    bus.ir_operand[15:8] <= bus.mem_data;
                    state                <= S_OUT;
                end
                S_OUT: begin
                    if (bus.ir_ready) begin
                        pc    <= pc + {14'd0, bus.ir_len};
                        state <= S_OP;
                    end
                end
                default: state <= S_RST;
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port mem_addr, output, 16 bits: byte address of the read issued this cycle.
REQ-004 SHALL have port mem_rd, output, 1 bit: read strobe; read data returns exactly one cycle later.
REQ-005 SHALL have port mem_data, input, 8 bits: read data for the previous cycle's mem_addr.
REQ-006 SHALL have port redirect, input, 1 bit: flush and restart fetch at redirect_pc (jump, branch, interrupt).
REQ-007 SHALL have port redirect_pc, input, 16 bits: new fetch address.
REQ-008 SHALL have port ir_valid, output, 1 bit: a complete instruction is presented downstream.
REQ-009 SHALL have port ir_ready, input, 1 bit: the downstream decode/execute accepts the instruction.
REQ-010 SHALL have port ir_opcode, output, 8 bits: opcode byte feeding the decoder.
REQ-011 SHALL have port ir_operand, output, 16 bits: {hi, lo} operand bytes; unused bytes are 0.
REQ-012 SHALL have port ir_pc, output, 16 bits: address of the opcode byte.
REQ-013 SHALL have port ir_len, output, 2 bits: instruction length, 1 to 3.

Function
REQ-014 SHALL implement the states S_RST, S_VEC0, S_VEC1, S_VEC2, S_OP, S_B1, S_B2, S_B3 and S_OUT; mem_addr and mem_rd are functions of the state and registers only.
REQ-015 S_RST SHALL drive mem_rd=0 and go to S_VEC0 on the first cycle with rst low.
REQ-016 S_VEC0 SHALL issue FFFC and go to S_VEC1; S_VEC1 SHALL issue FFFD, latch mem_data as pc[7:0] and go to S_VEC2; S_VEC2 SHALL drive mem_rd=0, latch mem_data as pc[15:8] and go to S_OP.
REQ-017 S_OP SHALL issue pc and go to S_B1.
REQ-018 S_B1 SHALL latch mem_data as the opcode, compute len from mem_data, issue pc+1 unconditionally, and go to S_OUT if len=1, otherwise to S_B2.
REQ-019 S_B2 SHALL latch the operand lo byte; if len=3 it SHALL issue pc+2 and go to S_B3, otherwise it SHALL drive mem_rd=0 and go to S_OUT.
REQ-020 S_B3 SHALL drive mem_rd=0, latch the operand hi byte and go to S_OUT.
REQ-021 S_OUT SHALL assert ir_valid and hold all ir_* stable until ir_ready; on the handshake it SHALL set pc to pc+len and go to S_OP, with mem_rd=0.
REQ-022 Length rule, first match wins:
  - opcodes 00, 40, 60 and ???_?10_?0: len 1.
  - opcode 20 (JSR), ???_011_??, ???_110_?1 and ???_111_??: len 3.
  - all other opcodes: len 2.
REQ-023 All pc arithmetic SHALL be modulo 2^16: an opcode at FFFF fetches its operand from 0000, and the next pc wraps.
REQ-024 Redirect SHALL take priority in every state except S_RST.
  - Next state is S_OP and pc is set to redirect_pc.
  - Any in-flight read data is discarded.
  - ir_valid is 0 on the next cycle.
REQ-025 If redirect and the S_OUT handshake occur in the same cycle, the instruction SHALL count as accepted and the next fetch SHALL be from redirect_pc.
REQ-026 The unit SHALL decode no opcode; illegal opcodes SHALL pass through using the length rule.

Reset
REQ-027 While rst is high, the state SHALL be S_RST with mem_rd=0, mem_addr=0000, ir_valid=0, ir_opcode=00, ir_operand=0000, ir_pc=0000, ir_len=1 and pc=0000.
REQ-028 rst asserted mid-fetch SHALL abandon the fetch and reload the reset vector after release.

Structure
REQ-029 State encoding and the constants FFFC/FFFD SHALL live in the shared 6502 definitions header alongside the OP_*, REG_* and ALU_* constants.
REQ-030 The length rule SHALL be a combinational sub-module, inst_len (opcode in, len out), so the decoder can reuse it.

Verification
REQ-031 Reset vector:
  - Stimulus: memory FFFC=00, FFFD=80.
  - Required: reads at FFFC, FFFD, then the first opcode read at 8000.
REQ-032 Three-byte instruction:
  - Stimulus: 8000: AD 34 12, ir_ready=1.
  - Required: ir_opcode=AD, ir_operand=1234, ir_len=3, ir_pc=8000; next opcode read at 8003.
REQ-033 Back-pressure, then one-byte instruction:
  - Stimulus: 8000: A9 55 (LDA #), ir_ready low 5 cycles, then E8.
  - Required: A9/0055/len 2 held stable with mem_rd=0 during the stall; then E8, operand 0000, len 1, ir_pc=8002.
REQ-034 Redirect mid-fetch:
  - Stimulus: redirect=1, redirect_pc=C000 while in S_B2.
  - Required: the partial instruction is dropped, no ir_valid, next read at C000.
REQ-035 Wrap-around:
  - Stimulus: pc=FFFF holding A9 and 0000 holding 7F.
  - Required: ir_operand=007F; next opcode read at 0001.
REQ-036 Simultaneous handshake and redirect:
  - Stimulus: ir_ready=1 and redirect_pc=9000 in the same cycle.
  - Required: exactly one accept; next read at 9000.
